// File: rtl/clk_counter_leds_modes.sv
// DE0-Nano top: free-running counter shown on LEDG, KEY[1] presses cycle UP/DOWN/GRAY/PAUSE.
// Define CLKCNT_SCANNER_EN to add a bouncing one-hot SCAN mode after PAUSE.
module clk_counter_leds_modes #(
    parameter int CNT_WIDTH       = 32,
    parameter int LED_WIDTH       = 8,
    parameter int LED_LSB         = CNT_WIDTH - LED_WIDTH,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                 EXTCLK,
    input  logic [1:0]           KEY,
    output logic [LED_WIDTH-1:0] LEDG
);
    localparam int             DBW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DBW-1:0] DB_MAX = DBW'(DEBOUNCE_CYCLES);

    localparam logic [2:0] ST_UP    = 3'd0;
    localparam logic [2:0] ST_DOWN  = 3'd1;
    localparam logic [2:0] ST_GRAY  = 3'd2;
    localparam logic [2:0] ST_PAUSE = 3'd3;
`ifdef CLKCNT_SCANNER_EN
    localparam logic [2:0] ST_SCAN  = 3'd4;
`endif

    logic                 w_rst_n;
    logic [1:0]           r_sync;
    logic                 r_deb;
    logic [DBW-1:0]       r_deb_cnt;
    logic                 r_press;
    logic [2:0]           r_mode;
    logic [2:0]           w_mode_nxt;
    logic [CNT_WIDTH-1:0] r_clkcounter;
    logic [LED_WIDTH-1:0] w_s;
    logic [LED_WIDTH-1:0] w_led_nxt;
    logic                 w_unused;

    assign w_rst_n  = KEY[0];
    assign w_s      = r_clkcounter[LED_LSB +: LED_WIDTH];
    assign w_unused = ^r_clkcounter;

    // Press pulse fires on the same edge the debounced level falls.
    always_ff @(posedge EXTCLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sync    <= 2'b11;
            r_deb     <= 1'b1;
            r_deb_cnt <= '0;
            r_press   <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], KEY[1]};
            r_press <= 1'b0;
            if (r_sync[1] == r_deb) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == DB_MAX) begin
                r_deb     <= r_sync[1];
                r_deb_cnt <= '0;
                r_press   <= r_deb;
            end else begin
                r_deb_cnt <= r_deb_cnt + DBW'(1);
            end
        end
    end

    always_comb begin
        w_mode_nxt = r_mode;
        if (r_press) begin
            case (r_mode)
                ST_UP:    w_mode_nxt = ST_DOWN;
                ST_DOWN:  w_mode_nxt = ST_GRAY;
                ST_GRAY:  w_mode_nxt = ST_PAUSE;
`ifdef CLKCNT_SCANNER_EN
                ST_PAUSE: w_mode_nxt = ST_SCAN;
`endif
                default:  w_mode_nxt = ST_UP;
            endcase
        end
    end

`ifdef CLKCNT_SCANNER_EN
    localparam int            PW      = $clog2(LED_WIDTH);
    localparam logic [PW-1:0] POS_MAX = PW'(LED_WIDTH - 1);

    logic [PW-1:0] r_pos;
    logic          r_dir_dn;
    logic          w_step;

    generate
        if (LED_LSB == 0) begin : g_step_all
            assign w_step = 1'b1;
        end else begin : g_step_lsb
            assign w_step = &r_clkcounter[LED_LSB-1:0];
        end
    endgenerate

    // Position only moves while in SCAN, so re-entry resumes where it left off.
    always_ff @(posedge EXTCLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_pos    <= '0;
            r_dir_dn <= 1'b0;
        end else if (r_mode == ST_SCAN && w_step) begin
            if (!r_dir_dn) begin
                if (r_pos == POS_MAX) begin
                    r_dir_dn <= 1'b1;
                    r_pos    <= r_pos - PW'(1);
                end else begin
                    r_pos <= r_pos + PW'(1);
                end
            end else begin
                if (r_pos == '0) begin
                    r_dir_dn <= 1'b0;
                    r_pos    <= PW'(1);
                end else begin
                    r_pos <= r_pos - PW'(1);
                end
            end
        end
    end
`endif

    always_comb begin
        w_led_nxt = w_s;
        case (r_mode)
            ST_GRAY: w_led_nxt = w_s ^ (w_s >> 1);
`ifdef CLKCNT_SCANNER_EN
            ST_SCAN: w_led_nxt = LED_WIDTH'(1) << r_pos;
`endif
            default: w_led_nxt = w_s;
        endcase
    end

    // Counter and LEDs both act on the pre-edge mode, so a wrap coinciding
    // with a press completes under the old mode.
    always_ff @(posedge EXTCLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_mode       <= ST_UP;
            r_clkcounter <= '0;
            LEDG         <= '0;
        end else begin
            r_mode <= w_mode_nxt;
            LEDG   <= w_led_nxt;
            case (r_mode)
                ST_DOWN:  r_clkcounter <= r_clkcounter - CNT_WIDTH'(1);
                ST_PAUSE: r_clkcounter <= r_clkcounter;
                default:  r_clkcounter <= r_clkcounter + CNT_WIDTH'(1);
            endcase
        end
    end

endmodule

// File: tb/tb_clk_counter_leds_modes.sv
// Bench for clk_counter_leds_modes with a small counter and short debounce.
module tb_clk_counter_leds_modes;
    localparam int CW = 8;
    localparam int LW = 4;
    localparam int LL = 0;
    localparam int D  = 4;
    localparam int M  = 1 << CW;
`ifdef CLKCNT_SCANNER_EN
    localparam int NMODES = 5;
`else
    localparam int NMODES = 4;
`endif

    logic          EXTCLK = 1'b0;
    logic [1:0]    KEY    = 2'b11;
    logic [LW-1:0] LEDG;

    clk_counter_leds_modes #(
        .CNT_WIDTH(CW), .LED_WIDTH(LW), .LED_LSB(LL), .DEBOUNCE_CYCLES(D)
    ) dut (
        .EXTCLK(EXTCLK), .KEY(KEY), .LEDG(LEDG)
    );

    always #5 EXTCLK = ~EXTCLK;

    int n_chk  = 0;
    int n_pass = 0;
    int edge_n = 0;
    // Model: mode 0 UP, 1 DOWN, 2 GRAY, 3 PAUSE, 4 SCAN; m_t is phase in the bounce cycle.
    int m_cnt  = 0;
    int m_mode = 0;
    int m_t    = 0;
    logic [LW-1:0] m_led = '0;
    int q_chg[$];

    function automatic logic [LW-1:0] disp(int mode, int cnt, int t);
        int s;
        int pos;
        s = (cnt >> LL) % (1 << LW);
        pos = (t < LW) ? t : 2 * (LW - 1) - t;
        case (mode)
            2:       return LW'(s ^ (s >> 1));
            4:       return LW'(1 << pos);
            default: return LW'(s);
        endcase
    endfunction

    task automatic tick();
        @(posedge EXTCLK);
        edge_n++;
        m_led = disp(m_mode, m_cnt, m_t);
        case (m_mode)
            1:       m_cnt = (m_cnt + M - 1) % M;
            3:       m_cnt = m_cnt;
            default: m_cnt = (m_cnt + 1) % M;
        endcase
        if (m_mode == 4) m_t = (m_t + 1) % (2 * (LW - 1));
        if (q_chg.size() > 0 && q_chg[0] == edge_n) begin
            void'(q_chg.pop_front());
            m_mode = (m_mode + 1) % NMODES;
        end
        #1;
    endtask

    task automatic model_reset();
        m_cnt = 0; m_mode = 0; m_t = 0; m_led = '0;
        q_chg.delete();
    endtask

    // Hold KEY[1] low for len sampled edges; a press registers only if len > D.
    task automatic press(input int len);
        KEY[1] = 1'b0;
        if (len >= D + 1) q_chg.push_back(edge_n + 1 + 3 + D);
        repeat (len) tick();
        KEY[1] = 1'b1;
    endtask

    task automatic test_reset();
        #2 KEY[0] = 1'b0;
        #1;
        n_chk++;
        if (LEDG !== 4'h0 || dut.r_clkcounter !== 8'h00)
            $display("FAIL reset_async: cnt=%h led=%h expected 00/0", dut.r_clkcounter, LEDG);
        else n_pass++;
        repeat (3) @(posedge EXTCLK);
        #1 KEY[0] = 1'b1;
        model_reset();
    endtask

    task automatic test_count_up();
        repeat (10) tick();
        n_chk++;
        if (dut.r_clkcounter !== 8'h0A || LEDG !== 4'h9)
            $display("FAIL count_10: cnt=%h led=%h expected 0a/9", dut.r_clkcounter, LEDG);
        else n_pass++;
        repeat (246) tick();
        n_chk++;
        if (dut.r_clkcounter !== 8'h00 || LEDG !== 4'hF)
            $display("FAIL count_256: cnt=%h led=%h expected 00/f", dut.r_clkcounter, LEDG);
        else n_pass++;
        for (int i = 0; i < 32; i++) begin
            tick();
            n_chk++;
            if (dut.r_clkcounter !== CW'(m_cnt) || LEDG !== m_led)
                $display("FAIL count_run: cnt=%h led=%h expected %h/%h", dut.r_clkcounter, LEDG, CW'(m_cnt), m_led);
            else n_pass++;
        end
    endtask

    task automatic test_press_down();
        press(10);
        for (int i = 0; i < 2 * D + 8 + 64; i++) begin
            tick();
            n_chk++;
            if (dut.r_clkcounter !== CW'(m_cnt) || LEDG !== m_led)
                $display("FAIL press_down: cnt=%h led=%h expected %h/%h", dut.r_clkcounter, LEDG, CW'(m_cnt), m_led);
            else n_pass++;
        end
    endtask

    task automatic test_glitch();
        int lens[2];
        lens[0] = 3;
        lens[1] = 1 + int'($urandom % D);
        for (int g = 0; g < 2; g++) begin
            press(lens[g]);
            for (int i = 0; i < 2 * D + 8; i++) begin
                tick();
                n_chk++;
                if (dut.r_clkcounter !== CW'(m_cnt) || LEDG !== m_led)
                    $display("FAIL glitch_len%0d: cnt=%h led=%h expected %h/%h", lens[g], dut.r_clkcounter, LEDG, CW'(m_cnt), m_led);
                else n_pass++;
            end
        end
    endtask

    task automatic test_gray_pause();
        int hold;
        press(D + 1 + int'($urandom_range(0, 5)));
        for (int i = 0; i < 2 * D + 8; i++) begin
            tick();
            n_chk++;
            if (dut.r_clkcounter !== CW'(m_cnt) || LEDG !== m_led)
                $display("FAIL gray_run: cnt=%h led=%h expected %h/%h", dut.r_clkcounter, LEDG, CW'(m_cnt), m_led);
            else n_pass++;
        end
        for (int i = 0; i < 16 && (m_cnt % 16) != 11; i++) tick();
        tick();
        n_chk++;
        if (LEDG !== 4'hE || LEDG !== m_led)
            $display("FAIL gray_b: led=%h expected e", LEDG);
        else n_pass++;
        press(D + 1 + int'($urandom_range(0, 5)));
        repeat (2 * D + 8) tick();
        hold = m_cnt;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_chk++;
            if (dut.r_clkcounter !== CW'(hold) || LEDG !== LW'(hold % 16))
                $display("FAIL pause_hold: cnt=%h led=%h expected %h/%h", dut.r_clkcounter, LEDG, CW'(hold), LW'(hold % 16));
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        KEY[1] = 1'b0;
        repeat (3) tick();
        #2 KEY[0] = 1'b0;
        #1;
        n_chk++;
        if (dut.r_clkcounter !== 8'h00 || LEDG !== 4'h0)
            $display("FAIL reset_mid: cnt=%h led=%h expected 00/0", dut.r_clkcounter, LEDG);
        else n_pass++;
        model_reset();
        KEY[1] = 1'b1;
        repeat (2) @(posedge EXTCLK);
        #1 KEY[0] = 1'b1;
        for (int i = 0; i < 2 * D + 10; i++) begin
            tick();
            n_chk++;
            if (dut.r_clkcounter !== CW'(m_cnt) || LEDG !== m_led)
                $display("FAIL reset_mid_after: cnt=%h led=%h expected %h/%h", dut.r_clkcounter, LEDG, CW'(m_cnt), m_led);
            else n_pass++;
        end
    endtask

    task automatic test_reset_held();
        KEY[1] = 1'b0;
        #2 KEY[0] = 1'b0;
        @(posedge EXTCLK);
        #1;
        model_reset();
        KEY[0] = 1'b1;
        q_chg.push_back(edge_n + 1 + 3 + D);
        for (int i = 0; i < 10 + 2 * D + 8; i++) begin
            if (i == 10) KEY[1] = 1'b1;
            tick();
            n_chk++;
            if (dut.r_clkcounter !== CW'(m_cnt) || LEDG !== m_led)
                $display("FAIL reset_held: cnt=%h led=%h expected %h/%h", dut.r_clkcounter, LEDG, CW'(m_cnt), m_led);
            else n_pass++;
        end
    endtask

    task automatic test_wrap_press();
        for (int i = 0; i < M && m_cnt != D + 3; i++) tick();
        press(D + 1 + int'($urandom_range(0, 2)));
        for (int i = 0; i < 2 * D + 8; i++) begin
            tick();
            n_chk++;
            if (dut.r_clkcounter !== CW'(m_cnt) || LEDG !== m_led)
                $display("FAIL wrap_press: cnt=%h led=%h expected %h/%h", dut.r_clkcounter, LEDG, CW'(m_cnt), m_led);
            else n_pass++;
        end
    endtask

    task automatic test_last_mode();
        logic [LW-1:0] scan_exp [8];
        scan_exp = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
        press(D + 1);
        repeat (2 * D + 8) tick();
        press(D + 1);
        for (int i = 0; i < 50 && q_chg.size() > 0; i++) tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            n_chk++;
`ifdef CLKCNT_SCANNER_EN
            if (LEDG !== scan_exp[i] || LEDG !== m_led)
                $display("FAIL scan_seq%0d: led=%h expected %h", i, LEDG, scan_exp[i]);
            else n_pass++;
`else
            if (dut.r_clkcounter !== CW'(m_cnt) || LEDG !== m_led || m_mode != 0)
                $display("FAIL pause_to_up: cnt=%h led=%h expected %h/%h", dut.r_clkcounter, LEDG, CW'(m_cnt), m_led);
            else n_pass++;
`endif
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_press_down();
        test_glitch();
        test_gray_pause();
        test_reset_mid();
        test_reset_held();
        test_wrap_press();
        test_last_mode();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
